// File: rtl/neural_network_pkg.sv
// rtl/neural_network_pkg.sv - shared types and defaults for the neuron datapath
package neural_network_pkg;

  typedef enum logic {
    relu,
    sigmoid
  } activation_type;

  typedef enum logic [1:0] {
    FILLING,
    FIRE,
    WAIT_DONE
  } buffer_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_INPUTS = 16;

endpackage

// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - serial-to-parallel sample assembler feeding the neuron
// Holds a framed vector stable until the neuron signals completion.
module input_buffer
  import neural_network_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
  output logic                         input_ready,
  input  logic                         neuron_done,
  output logic                         busy,
  output logic [$clog2(NUM_INPUTS+1)-1:0] fill_level,
  output logic                         frame_error
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam int FW = $clog2(NUM_INPUTS + 1);
  localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_INPUTS - 1);

  buffer_state_t state;
  logic [IW-1:0] index;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FILLING;
      index       <= '0;
      fill_level  <= '0;
      input_ready <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) inputs[i] <= '0;
    end else if (clear) begin
      state       <= FILLING;
      index       <= '0;
      fill_level  <= '0;
      input_ready <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) inputs[i] <= '0;
    end else begin
      input_ready <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        FILLING: begin
          if (in_valid) begin
            inputs[index] <= in_data;
            if (index == LAST_INDEX && in_last) begin
              // Index wraps to 0 here so it never exceeds the last slot.
              state       <= FIRE;
              input_ready <= 1'b1;
              busy        <= 1'b1;
              index       <= '0;
              fill_level  <= FW'(NUM_INPUTS);
            end else if (index == LAST_INDEX || in_last) begin
              // Misframed vector: restart; stale samples get overwritten.
              frame_error <= 1'b1;
              index       <= '0;
              fill_level  <= '0;
            end else begin
              index      <= index + IW'(1);
              fill_level <= fill_level + FW'(1);
            end
          end
        end
        FIRE: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (neuron_done) begin
            state      <= FILLING;
            busy       <= 1'b0;
            index      <= '0;
            fill_level <= '0;
          end
        end
        default: begin
          state <= FILLING;
        end
      endcase
    end
  end

  always_comb begin
    in_ready = (state == FILLING);
  end

endmodule
